// File: rtl/cprv_pkg.sv
// Shared constants and types for the cprv instruction-fetch front end.
// Holds no logic, so it adds no latency and has no backpressure behaviour.
package cprv_pkg;

  localparam int CPRV_XLEN        = 64;
  localparam int CPRV_INSTR_WIDTH = 32;
  localparam int PC_STEP          = 4;

  typedef struct packed {
    logic [CPRV_XLEN-1:0]        pc;
    logic [CPRV_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/cprv_sync_fifo.sv
// Synchronous FIFO with occupancy count and a flush that empties it in one cycle.
// A push is visible at pop_data the next cycle. A push into a full FIFO is dropped unless a pop happens in the same cycle.
module cprv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // An empty FIFO presents zero, so the head is defined right after reset.
  assign pop_data = (count_q != '0) ? mem[rd_ptr] : '0;
  assign count    = count_q;

endmodule

// File: rtl/cprv_fetch_unit.sv
// Fetch front end: owns the PC, keeps up to MAX_OUTSTANDING imem requests in flight, and queues responses for ID.
// A response accepted in cycle N is presented to ID in cycle N+1. Requests are credit-limited by queue space, so responses are never backpressured.
module cprv_fetch_unit
  import cprv_pkg::*;
#(
  parameter int                    DATA_WIDTH      = CPRV_XLEN,
  parameter int                    INSTR_WIDTH     = CPRV_INSTR_WIDTH,
  parameter int                    FQ_DEPTH        = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid_i,
  input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
  output logic                   valid_imem_o,
  input  logic                   ready_imem_i,
  output logic [DATA_WIDTH-1:0]  instr_addr_imem_o,
  input  logic                   valid_if_i,
  output logic                   ready_if_o,
  input  logic [INSTR_WIDTH-1:0] instr_data_imem_i,
  output logic                   valid_id_o,
  input  logic                   ready_id_i,
  output logic [INSTR_WIDTH-1:0] instr_data_id_o,
  output logic [DATA_WIDTH-1:0]  instr_pc_id_o
);

  localparam int TW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FQ_DEPTH + 1);
  localparam int SW  = FCW + 1;
  localparam int EW  = DATA_WIDTH + INSTR_WIDTH;

  localparam logic [SW-1:0]  FQ_LIM  = SW'(FQ_DEPTH);
  localparam logic [OCW-1:0] OUT_LIM = OCW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0]  TRK_TOP = TW'(MAX_OUTSTANDING - 1);

  logic [DATA_WIDTH-1:0]      pc;
  logic [DATA_WIDTH-1:0]      trk_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] trk_stale;
  logic [TW-1:0]              trk_wr;
  logic [TW-1:0]              trk_rd;
  logic [OCW-1:0]             occ_out;
  logic [FCW-1:0]             occ_fq;
  logic [SW-1:0]              occ_sum;
  logic                       req_fire;
  logic                       rsp_fire;
  logic                       fq_push;
  logic [EW-1:0]              fq_head;

  function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] p);
    return (p == TRK_TOP) ? '0 : p + TW'(1);
  endfunction

  // Stale requests still hold credit, so queue space is reserved for every response in flight.
  assign occ_sum           = SW'(occ_out) + SW'(occ_fq);
  assign valid_imem_o      = (occ_sum < FQ_LIM) && (occ_out < OUT_LIM);
  assign instr_addr_imem_o = pc;
  assign ready_if_o        = (occ_out != '0);

  assign req_fire = valid_imem_o && ready_imem_i;
  assign rsp_fire = valid_if_i && ready_if_o;
  assign fq_push  = rsp_fire && !trk_stale[trk_rd] && !redirect_valid_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      trk_wr    <= '0;
      trk_rd    <= '0;
      trk_stale <= '0;
      occ_out   <= '0;
    end else begin
      if (redirect_valid_i) pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      else if (req_fire)    pc <= pc + DATA_WIDTH'(PC_STEP);

      if (req_fire) begin
        trk_stale[trk_wr] <= redirect_valid_i;
        trk_wr            <= trk_inc(trk_wr);
      end
      if (rsp_fire) trk_rd <= trk_inc(trk_rd);
      // A redirect poisons everything in flight, including this cycle's push.
      if (redirect_valid_i) trk_stale <= '1;

      if (req_fire && !rsp_fire)      occ_out <= occ_out + OCW'(1);
      else if (rsp_fire && !req_fire) occ_out <= occ_out - OCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) trk_pc[trk_wr] <= pc;
  end

  cprv_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid_i),
    .push      (fq_push),
    .push_data ({trk_pc[trk_rd], instr_data_imem_i}),
    .pop       (valid_id_o && ready_id_i),
    .pop_data  (fq_head),
    .count     (occ_fq)
  );

  assign valid_id_o                       = (occ_fq != '0);
  assign {instr_pc_id_o, instr_data_id_o} = fq_head;

endmodule

// File: tb/tb_cprv_fetch_unit.sv
// Self-checking bench for cprv_fetch_unit: a 1-cycle-latency imem model plus an epoch-tagged scoreboard of what ID must see.
module tb_cprv_fetch_unit;
  import cprv_pkg::*;

  localparam int DW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_valid_i = 1'b0;
  logic [DW-1:0] redirect_pc_i = '0;
  logic          valid_imem_o;
  logic          ready_imem_i = 1'b0;
  logic [DW-1:0] instr_addr_imem_o;
  logic          valid_if_i = 1'b0;
  logic          ready_if_o;
  logic [IW-1:0] instr_data_imem_i = '0;
  logic          valid_id_o;
  logic          ready_id_i = 1'b0;
  logic [IW-1:0] instr_data_id_o;
  logic [DW-1:0] instr_pc_id_o;

  always #5 clk = ~clk;

  cprv_fetch_unit #(
    .DATA_WIDTH      (DW),
    .INSTR_WIDTH     (IW),
    .FQ_DEPTH        (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        ('0)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .valid_imem_o      (valid_imem_o),
    .ready_imem_i      (ready_imem_i),
    .instr_addr_imem_o (instr_addr_imem_o),
    .valid_if_i        (valid_if_i),
    .ready_if_o        (ready_if_o),
    .instr_data_imem_i (instr_data_imem_i),
    .valid_id_o        (valid_id_o),
    .ready_id_i        (ready_id_i),
    .instr_data_id_o   (instr_data_id_o),
    .instr_pc_id_o     (instr_pc_id_o)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [DW-1:0] imem_q[$];
  int            ep_q[$];
  fetch_entry_t  exp_q[$];
  logic [DW-1:0] id_log[$];
  int            epoch = 0;
  int            cyc = 0;
  int            first_id_cyc = -1;
  bit            imem_hold = 1'b0;

  function automatic logic [IW-1:0] instr_of(input logic [DW-1:0] a);
    return a[IW+1:2] ^ 32'h1357_9bdf;
  endfunction

  // One clock: sample at negedge, update model, then drive next-cycle imem response.
  task automatic tick();
    fetch_entry_t e;
    @(negedge clk);
    if (valid_if_i) begin
      n_tests++;
      if (!ready_if_o) begin
        n_fail++;
        $display("FAIL rsp_backpressure cyc=%0d ready_if_o=%b required=1", cyc, ready_if_o);
      end
    end
    if (valid_id_o && ready_id_i) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL id_unexpected cyc=%0d pc=%h (nothing expected)", cyc, instr_pc_id_o);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc_id_o !== e.pc || instr_data_id_o !== e.instr) begin
          n_fail++;
          $display("FAIL id_entry cyc=%0d got pc=%h instr=%h required pc=%h instr=%h",
                   cyc, instr_pc_id_o, instr_data_id_o, e.pc, e.instr);
        end
      end
      id_log.push_back(instr_pc_id_o);
      if (first_id_cyc < 0) first_id_cyc = cyc;
    end
    if (valid_if_i && ready_if_o && imem_q.size() != 0) begin
      e.pc    = imem_q.pop_front();
      e.instr = instr_of(e.pc);
      if (ep_q.pop_front() == epoch && !redirect_valid_i) exp_q.push_back(e);
    end
    if (valid_imem_o && ready_imem_i) begin
      imem_q.push_back(instr_addr_imem_o);
      ep_q.push_back(epoch);
    end
    if (redirect_valid_i) begin
      exp_q.delete();
      epoch++;
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid_i  = 1'b0;
    valid_if_i        = (imem_q.size() != 0) && !imem_hold;
    instr_data_imem_i = valid_if_i ? instr_of(imem_q[0]) : '0;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    valid_if_i        = 1'b0;
    instr_data_imem_i = '0;
    redirect_valid_i  = 1'b0;
    redirect_pc_i     = '0;
    ready_imem_i      = 1'b0;
    ready_id_i        = 1'b0;
    imem_hold         = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_q.delete();
    ep_q.delete();
    exp_q.delete();
    id_log.delete();
    epoch        = 0;
    cyc          = 1;
    first_id_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests += 6;
    if (valid_imem_o !== 1'b1) begin n_fail++; $display("FAIL %s_valid_imem got=%b required=1", tag, valid_imem_o); end
    if (instr_addr_imem_o !== 64'h0) begin n_fail++; $display("FAIL %s_addr got=%h required=0", tag, instr_addr_imem_o); end
    if (ready_if_o !== 1'b0) begin n_fail++; $display("FAIL %s_ready_if got=%b required=0", tag, ready_if_o); end
    if (valid_id_o !== 1'b0) begin n_fail++; $display("FAIL %s_valid_id got=%b required=0", tag, valid_id_o); end
    if (instr_data_id_o !== 32'h0) begin n_fail++; $display("FAIL %s_id_instr got=%h required=0", tag, instr_data_id_o); end
    if (instr_pc_id_o !== 64'h0) begin n_fail++; $display("FAIL %s_id_pc got=%h required=0", tag, instr_pc_id_o); end
  endtask

  task automatic wait_id(input int need, input string tag);
    for (int i = 0; i < 30 && id_log.size() < need; i++) tick();
    n_tests++;
    if (id_log.size() < need) begin
      n_fail++;
      $display("FAIL %s_timeout got=%0d id outputs required=%0d", tag, id_log.size(), need);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_stream();
    do_reset();
    ready_imem_i = 1'b1;
    ready_id_i   = 1'b1;
    repeat (5) tick();
    n_tests += 2;
    if (first_id_cyc !== 3) begin n_fail++; $display("FAIL stream_latency got=%0d required=3", first_id_cyc); end
    if (id_log.size() != 3) begin
      n_fail++;
      $display("FAIL stream_count got=%0d required=3", id_log.size());
    end else begin
      n_tests += 3;
      if (id_log[0] !== 64'h0) begin n_fail++; $display("FAIL stream_pc0 got=%h required=0", id_log[0]); end
      if (id_log[1] !== 64'h4) begin n_fail++; $display("FAIL stream_pc1 got=%h required=4", id_log[1]); end
      if (id_log[2] !== 64'h8) begin n_fail++; $display("FAIL stream_pc2 got=%h required=8", id_log[2]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_imem_i = 1'b1;
    repeat (12) tick();
    n_tests += 4;
    if (valid_imem_o !== 1'b0) begin n_fail++; $display("FAIL bp_valid_imem got=%b required=0", valid_imem_o); end
    if (exp_q.size() != 4) begin n_fail++; $display("FAIL bp_buffered got=%0d required=4", exp_q.size()); end
    if (ready_if_o !== 1'b0) begin n_fail++; $display("FAIL bp_outstanding ready_if=%b required=0", ready_if_o); end
    if (valid_id_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_id got=%b required=1", valid_id_o); end
    ready_id_i = 1'b1;
    wait_id(4, "bp_drain");
    if (id_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (id_log[i] !== 64'(4 * i)) begin
          n_fail++;
          $display("FAIL bp_order idx=%0d got=%h required=%h", i, id_log[i], 64'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    imem_hold        = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h10;
    tick();
    ready_imem_i = 1'b1;
    ready_id_i   = 1'b1;
    tick();
    tick();
    n_tests += 2;
    if (valid_imem_o !== 1'b0) begin n_fail++; $display("FAIL rd_credit got=%b required=0", valid_imem_o); end
    if (imem_q.size() != 2 || imem_q[0] !== 64'h10 || imem_q[1] !== 64'h14) begin
      n_fail++;
      $display("FAIL rd_outstanding got=%0d requests required 0x10,0x14", imem_q.size());
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h203;
    imem_hold        = 1'b0;
    tick();
    n_tests++;
    if (instr_addr_imem_o !== 64'h200) begin n_fail++; $display("FAIL rd_addr got=%h required=200", instr_addr_imem_o); end
    wait_id(1, "rd_next");
    if (id_log.size() >= 1) begin
      n_tests++;
      if (id_log[0] !== 64'h200) begin n_fail++; $display("FAIL rd_first_pc got=%h required=200", id_log[0]); end
    end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    ready_imem_i = 1'b1;
    tick();
    tick();
    n_tests++;
    if (!(valid_imem_o && valid_if_i && ready_if_o && valid_id_o)) begin
      n_fail++;
      $display("FAIL rc_setup got req=%b rsp=%b rdy=%b id=%b required all 1",
               valid_imem_o, valid_if_i, ready_if_o, valid_id_o);
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h1000;
    ready_id_i       = 1'b1;
    tick();
    n_tests++;
    if (valid_id_o !== 1'b0) begin n_fail++; $display("FAIL rc_flush valid_id got=%b required=0", valid_id_o); end
    id_log.delete();
    wait_id(1, "rc_next");
    if (id_log.size() >= 1) begin
      n_tests++;
      if (id_log[0] !== 64'h1000) begin n_fail++; $display("FAIL rc_first_pc got=%h required=1000", id_log[0]); end
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    n_tests++;
    if (instr_addr_imem_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_top got=%h required=fffffffffffffffc", instr_addr_imem_o);
    end
    ready_imem_i = 1'b1;
    ready_id_i   = 1'b1;
    tick();
    n_tests++;
    if (instr_addr_imem_o !== 64'h0) begin n_fail++; $display("FAIL wrap_addr got=%h required=0", instr_addr_imem_o); end
    wait_id(2, "wrap_id");
    if (id_log.size() >= 2) begin
      n_tests += 2;
      if (id_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_id0 got=%h required=fffffffffffffffc", id_log[0]); end
      if (id_log[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_id1 got=%h required=0", id_log[1]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_imem_i = 1'b1;
    tick();
    tick();
    imem_hold = 1'b1;
    tick();
    tick();
    n_tests += 2;
    if (imem_q.size() != 2) begin n_fail++; $display("FAIL rm_outstanding got=%0d required=2", imem_q.size()); end
    if (exp_q.size() != 2) begin n_fail++; $display("FAIL rm_queued got=%0d required=2", exp_q.size()); end
    do_reset();
    check_reset_outputs("rm");
    ready_imem_i = 1'b1;
    ready_id_i   = 1'b1;
    repeat (4) tick();
    n_tests += 2;
    if (first_id_cyc !== 3) begin n_fail++; $display("FAIL rm_latency got=%0d required=3", first_id_cyc); end
    if (id_log.size() == 0 || id_log[0] !== 64'h0) begin
      n_fail++; $display("FAIL rm_restart_pc got=%0d outputs, first pc required=0", id_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_pc_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
